// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester and transmitter handshake bundle for uart_tx_arbiter.
// Revision : 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDW     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_accept;
    logic                     tx_ready;
    logic                     tx_start;
    logic [WIDTH-1:0]         tx_data;
    logic [IDW-1:0]           grant_id;
    logic                     busy;

    modport master (
        input  req_valid, req_data, req_last, tx_ready,
        output req_accept, tx_start, tx_data, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, req_last, tx_ready,
        input  req_accept, tx_start, tx_data, grant_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter sharing one UART transmitter among NUM_REQ
//            requesters; optional packet lock via UART_TX_ARBITER_PACKET_LOCK_EN.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic              clock,
    input  logic              reset,
    uart_tx_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OFFER = 2'd1,
        S_FRAME = 2'd2
    } state_t;

    localparam logic [IDW:0]   c_num_req  = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] c_last_idx = IDW'(NUM_REQ-1);

    state_t             state_q;
    logic [IDW-1:0]     rr_ptr_q;
    logic [IDW-1:0]     grant_id_q;
    logic               tx_start_q;
    logic               busy_q;
    logic [WIDTH-1:0]   tx_data_q;
    logic [NUM_REQ-1:0] req_accept_q;

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic               w_found;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_next_ptr;
    logic [IDW:0]       w_idx;
    logic [WIDTH-1:0]   w_win_data;

`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
    logic lock_q;

    // While a packet is open only its owner (the last grantee) may win.
    always_comb begin
        w_eligible = bus.req_valid;
        if (lock_q) begin
            w_eligible             = '0;
            w_eligible[grant_id_q] = bus.req_valid[grant_id_q];
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^bus.req_last;
    assign w_eligible    = bus.req_valid;
`endif

    // First eligible requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (w_idx >= c_num_req) begin
                w_idx = w_idx - c_num_req;
            end
            if (!w_found && w_eligible[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_win_onehot = '0;
        w_win_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_win_onehot[i] = 1'b1;
                w_win_data      = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_next_ptr = (w_win == c_last_idx) ? '0 : w_win + IDW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            tx_data_q    <= '0;
            req_accept_q <= '0;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
            lock_q       <= 1'b0;
`endif
        end else begin
            req_accept_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (bus.tx_ready && w_found) begin
                        req_accept_q <= w_win_onehot;
                        tx_data_q    <= w_win_data;
                        grant_id_q   <= w_win;
                        tx_start_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_OFFER;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
                        lock_q       <= ~bus.req_last[w_win];
                        if (bus.req_last[w_win]) begin
                            rr_ptr_q <= w_next_ptr;
                        end
`else
                        rr_ptr_q     <= w_next_ptr;
`endif
                    end
                end
                // ready stays high through a previous stop bit, so hold the offer
                S_OFFER: begin
                    if (!bus.tx_ready) begin
                        tx_start_q <= 1'b0;
                        state_q    <= S_FRAME;
                    end
                end
                S_FRAME: begin
                    if (bus.tx_ready) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_accept = req_accept_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Self-checking bench for uart_tx_arbiter with a transmitter model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int N         = 4;
    localparam int W         = 8;
    localparam int IDW       = 2;
    localparam int BIT_CYC   = 4;
    localparam int FRAME_CYC = 10 * BIT_CYC;
    localparam int QD        = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;

    uart_tx_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .IDW(IDW)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // requester word stores: {last, data}
    logic [W:0]   rmem [N][QD];
    int           rhead [N];
    int           rtail [N];
    logic [N-1:0] en     = '0;
    logic         tx_rst = 1'b0;
    int           tx_cnt = 0;

    logic [W-1:0] tx_expect [$];
    logic [W-1:0] sent_log  [$];
    int           acc_log   [$];

    int   ref_ptr     = 0;
    logic ref_lock    = 1'b0;
    int   ref_lock_id = 0;

    logic [N-1:0]   snap_valid  = '0;
    logic [N*W-1:0] snap_data   = '0;
    logic [N-1:0]   snap_last   = '0;
    logic           snap_ready  = 1'b0;
    logic           snap_start  = 1'b0;
    logic [W-1:0]   snap_txdata = '0;
    logic           snap_rst    = 1'b1;
    logic [W-1:0]   prev_txdata = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_winner(input logic [N-1:0] v);
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
        if (ref_lock) return v[ref_lock_id] ? ref_lock_id : -1;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(ref_ptr + k) % N]) return (ref_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic all_empty();
        for (int i = 0; i < N; i++) begin
            if (rhead[i] != rtail[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic drained();
        return all_empty() && (tx_cnt == 0) && !bus.busy && (tx_expect.size() == 0);
    endfunction

    // Requesters and transmitter model, updated just after each rising edge.
    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_ready  = 1'b0;
        forever begin
            logic [N-1:0]   v;
            logic [N*W-1:0] d;
            logic [N-1:0]   l;
            @(posedge clock);
            #1;
            for (int i = 0; i < N; i++) begin
                if (bus.req_accept[i] && rhead[i] != rtail[i]) rhead[i]++;
            end
            if (tx_rst) begin
                tx_cnt       = 0;
                bus.tx_ready = 1'b0;
            end else if (tx_cnt == 0) begin
                if (snap_start) begin
                    if (tx_expect.size() == 0) begin
                        check_eq("spurious_tx_start", 32'd1, 32'd0);
                    end else begin
                        check_eq("tx_word", snap_txdata, tx_expect.pop_front());
                    end
                    sent_log.push_back(snap_txdata);
                    tx_cnt       = FRAME_CYC;
                    bus.tx_ready = 1'b0;
                end else begin
                    bus.tx_ready = 1'b1;
                end
            end else begin
                tx_cnt--;
                bus.tx_ready = (tx_cnt <= BIT_CYC);
            end
            v = '0; d = '0; l = '0;
            for (int i = 0; i < N; i++) begin
                if (rhead[i] != rtail[i]) begin
                    v[i]         = en[i];
                    d[i*W +: W]  = rmem[i][rhead[i]][W-1:0];
                    l[i]         = rmem[i][rhead[i]][W];
                end
            end
            bus.req_valid = v;
            bus.req_data  = d;
            bus.req_last  = l;
        end
    end

    // Monitor on the falling edge: judges the grant made at the previous rising edge.
    initial begin
        forever begin
            int           w;
            logic [N-1:0] expmask;
            @(negedge clock);
            if (snap_rst) begin
                ref_ptr  = 0;
                ref_lock = 1'b0;
                check_eq("rst_req_accept", bus.req_accept, 0);
                check_eq("rst_tx_start",   bus.tx_start,   0);
                check_eq("rst_tx_data",    bus.tx_data,    0);
                check_eq("rst_grant_id",   bus.grant_id,   0);
                check_eq("rst_busy",       bus.busy,       0);
            end else if (bus.req_accept != '0) begin
                w       = ref_winner(snap_valid);
                expmask = '0;
                if (w >= 0) expmask[w] = 1'b1;
                check_eq("accept_onehot", bus.req_accept, expmask);
                check_eq("ready_at_grant", snap_ready, 1);
                if (w >= 0) begin
                    check_eq("grant_tx_data",  bus.tx_data,  snap_data[w*W +: W]);
                    check_eq("grant_id",       bus.grant_id, w);
                    check_eq("grant_tx_start", bus.tx_start, 1);
                    check_eq("grant_busy",     bus.busy,     1);
                    tx_expect.push_back(snap_data[w*W +: W]);
                    acc_log.push_back(w);
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
                    if (snap_last[w]) begin
                        ref_lock = 1'b0;
                        ref_ptr  = (w + 1) % N;
                    end else begin
                        ref_lock    = 1'b1;
                        ref_lock_id = w;
                    end
`else
                    ref_ptr = (w + 1) % N;
`endif
                end
            end else begin
                check_eq("tx_data_hold", bus.tx_data, prev_txdata);
            end
            prev_txdata = bus.tx_data;
            snap_valid  = bus.req_valid;
            snap_data   = bus.req_data;
            snap_last   = bus.req_last;
            snap_ready  = bus.tx_ready;
            snap_start  = bus.tx_start;
            snap_txdata = bus.tx_data;
            snap_rst    = reset;
        end
    end

    task automatic push_word(input int i, input logic [W-1:0] data, input logic last);
        rmem[i][rtail[i]] = {last, data};
        rtail[i]++;
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic reset_bench();
        en = '0;
        pulse_reset();
        for (int i = 0; i < N; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        acc_log.delete();
        sent_log.delete();
        tx_expect.delete();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int c = 0;
        while (!drained() && c < budget) begin
            @(posedge clock); #1;
            c++;
        end
        check_eq(tag, drained(), 1);
    endtask

    task automatic wait_acc(input int n, input int budget);
        int c = 0;
        while (acc_log.size() < n && c < budget) begin
            @(posedge clock); #1;
            c++;
        end
        check_eq("wait_accept", acc_log.size() >= n, 1);
    endtask

    task automatic wait_frame(input int budget);
        int c = 0;
        while (!(bus.busy && !bus.tx_start && tx_cnt > 20) && c < budget) begin
            @(posedge clock); #1;
            c++;
        end
        check_eq("wait_frame", c < budget, 1);
    endtask

    initial begin
        int exp_seq [6];
        int nb;
        logic did_rst;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Single requester
        reset_bench();
        push_word(1, 8'hA5, 1'b1);
        en = 4'b0010;
        wait_drain("t1_drain", 500);
        check_eq("t1_accepts", acc_log.size(), 1);
        if (acc_log.size() > 0) check_eq("t1_winner", acc_log[0], 1);
        check_eq("t1_sent", sent_log.size(), 1);
        if (sent_log.size() > 0) check_eq("t1_word", sent_log[0], 8'hA5);
        check_eq("t1_tx_data", bus.tx_data, 8'hA5);
        check_eq("t1_grant_id", bus.grant_id, 1);
        check_eq("t1_busy", bus.busy, 0);

        // All four valid: rotation and stop-bit back-to-back offers
        reset_bench();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) push_word(i, 8'h10 + W'(i), 1'b1);
        end
        en = '1;
        wait_drain("t2_drain", 1500);
        check_eq("t2_accepts", acc_log.size(), 8);
        check_eq("t2_sent", sent_log.size(), 8);
        for (int k = 0; k < 5 && k < sent_log.size(); k++) begin
            check_eq($sformatf("t2_order%0d", k), sent_log[k], 8'h10 + (k % 4));
        end

        // Packet stimulus: requester 2 sends 3 words, requester 0 always pending
        reset_bench();
        push_word(2, 8'h20, 1'b0);
        push_word(2, 8'h21, 1'b0);
        push_word(2, 8'h22, 1'b1);
        for (int k = 0; k < 3; k++) push_word(0, 8'h30 + W'(k), 1'b1);
        en = 4'b0100;
        wait_acc(1, 200);
        en = 4'b0101;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
        wait_acc(2, 200);
        en[2] = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        check_eq("t3_stall", acc_log.size(), 2);
        en[2] = 1'b1;
        exp_seq = '{2, 2, 2, 0, 0, 0};
`else
        exp_seq = '{2, 0, 2, 0, 2, 0};
`endif
        wait_drain("t3_drain", 1500);
        check_eq("t3_accepts", acc_log.size(), 6);
        for (int k = 0; k < 6 && k < acc_log.size(); k++) begin
            check_eq($sformatf("t3_order%0d", k), acc_log[k], exp_seq[k]);
        end

        // Transmitter held not-ready: no grant may be issued
        reset_bench();
        tx_rst = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < N; i++) push_word(i, 8'h50 + W'(i), 1'b1);
        en = '1;
        repeat (50) @(posedge clock);
        #1;
        check_eq("t4_no_grant", acc_log.size(), 0);
        tx_rst = 1'b0;
        wait_drain("t4_drain", 1000);
        check_eq("t4_accepts", acc_log.size(), 4);
        if (acc_log.size() > 0) check_eq("t4_first", acc_log[0], 0);

        // Reset mid-frame: next grant restarts at requester 0
        reset_bench();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) push_word(i, 8'h60 + W'(8*r + i), 1'b1);
        end
        en = '1;
        wait_acc(2, 300);
        wait_frame(300);
        nb = acc_log.size();
        pulse_reset();
        wait_drain("t5_drain", 2000);
        check_eq("t5_more_grants", acc_log.size() > nb, 1);
        if (acc_log.size() > nb) check_eq("t5_first_after_rst", acc_log[nb], 0);

        // Randomized traffic with toggling valids and one mid-frame reset
        reset_bench();
        for (int k = 0; k < 40; k++) begin
            int r;
            r = $urandom_range(0, N-1);
            push_word(r, W'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < N; i++) begin
            if (rtail[i] > 0) rmem[i][rtail[i]-1][W] = 1'b1;
        end
        en      = '1;
        did_rst = 1'b0;
        for (int c = 0; c < 4000 && !drained(); c++) begin
            @(posedge clock); #1;
            if ($urandom_range(0, 7) == 0) begin
                int b;
                b     = $urandom_range(0, N-1);
                en[b] = ~en[b];
            end
            if (!did_rst && c > 300 && bus.busy && !bus.tx_start && tx_cnt > 20) begin
                did_rst = 1'b1;
                pulse_reset();
            end
        end
        en = '1;
        wait_drain("t6_drain", 4000);
        check_eq("t6_accepts", acc_log.size(), 40);
        check_eq("t6_sent", sent_log.size(), 40);
        check_eq("t6_mid_reset", did_rst, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `NUM_REQ` word-producing requesters. It picks a requester, latches that requester's word, and offers the word to the transmitter using the transmitter's `ready` / `can_send_next_word` handshake. It then holds off until the transmitter's frame, including the stop bit, has finished. It sits between the producers (status reporters, debug dumpers, buffer drains) and the single `uart_tx` instance driving the pin.

## Interface
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `WIDTH`, default 8: data word width; must equal the transmitter's `width`.
- `IDW`, default `$clog2(NUM_REQ)`: width of the grant index.

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i has a word pending.
- `req_data`  in  NUM_REQ*WIDTH  word of requester i at bits `[i*WIDTH +: WIDTH]`.
- `req_last`  in  NUM_REQ  word of requester i ends its packet (used only under packet lock).
- `req_accept`  out  NUM_REQ  one-hot, one-cycle pulse: requester i's word was taken.
- `tx_ready`  in  1  transmitter's `ready`.
- `tx_start`  out  1  drives the transmitter's `can_send_next_word`.
- `tx_data`  out  WIDTH  drives the transmitter's `data`.
- `grant_id`  out  IDW  index of the requester that owns the current or most recent word.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, OFFER, FRAME.
- **IDLE**
  - Grants only when `tx_ready`=1 and at least one `req_valid` is set.
  - Winner = first set `req_valid` scanning upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - On grant:
    - `req_accept[winner]` pulses.
    - `tx_data` ← `req_data[winner]`; `grant_id` ← winner.
    - `rr_ptr` ← winner+1; at NUM_REQ-1 it wraps to 0.
    - Next state is OFFER.
- **OFFER**
  - `tx_start`=1 with `tx_data` held stable.
  - When `tx_ready` samples 0 (the transmitter accepted the word), `tx_start`←0 and next state is FRAME.
  - `tx_start` stays high for as long as the transmitter is still counting down a previous stop bit.
- **FRAME**
  - Waits for `tx_ready`=1, then returns to IDLE.
- A requester's word is consumed exactly once, on its `req_accept` pulse. Requesters must hold `req_valid` and `req_data` until that pulse.
- `tx_data` is registered and changes only on a grant.
- Reset values: state IDLE, `rr_ptr` 0, `tx_start` 0, `tx_data` 0, `req_accept` 0, `grant_id` 0, `busy` 0, packet lock cleared.
- Boundary conditions:
  - Single valid requester: it wins every grant, with no starvation penalty.
  - All requesters valid: grants rotate 0,1,2,3,0,…
  - Requester drops `req_valid` while not granted: no effect on the arbiter.
  - Reset mid-frame: the arbiter returns to IDLE. It grants again only once `tx_ready`=1, so it never overlaps a frame the transmitter is still sending.
  - `tx_ready`=0 while in IDLE (transmitter under reset or still busy): no grant is issued.

## Timing
- Grant decision is combinational from `req_valid` and `rr_ptr` in IDLE. All outputs are registered.
- IDLE grant edge → `tx_start`=1 on the following cycle, with `req_accept` high in that same cycle.
- With the transmitter idle, its `ready` falls one cycle after it samples `tx_start`. FRAME is therefore entered 2 cycles after `tx_start` rises.
- Minimum spacing between grants = transmitter frame time (1 start bit + WIDTH data bits + 1 stop bit) + 3 arbiter cycles.
- At most one word is in flight; there is no internal queue.

## Configuration
- Macro: `UART_TX_ARBITER_PACKET_LOCK_EN`.
- **Defined**:
  - A grant whose `req_last[winner]`=0 sets a lock on `grant_id`.
  - While locked, IDLE considers only the locked requester. If its `req_valid`=0, the arbiter waits and other requesters stall.
  - A granted word with `req_last`=1 clears the lock.
  - `rr_ptr` advances only when the lock clears.
- **Undefined**:
  - `req_last` is ignored and no lock state is synthesized.
  - Arbitration is per word.
- Port list is identical in both builds.

## Test plan
- Single requester: `req_valid`=4'b0010, `req_data[1]`=8'hA5. Expect:
  - `req_accept`=4'b0010 once.
  - `tx_start` high until `tx_ready` falls.
  - `tx_data`=8'hA5 and `grant_id`=1.
  - `busy` low after `tx_ready` returns high.
- All four requesters valid continuously with data 8'h10..8'h13: serial output order 10,11,12,13,10; one `req_accept` per frame.
- Back-to-back requests while the transmitter is still in its stop bit: `tx_start` stays asserted through the countdown and the word is sent exactly once, with no duplicate `req_accept`.
- Reset pulsed mid-frame:
  - All arbiter outputs return to reset values the cycle after.
  - No grant occurs while `tx_ready`=0.
  - The next grant goes to requester 0 first.
- Packet lock defined: requester 2 sends 3 words (`req_last` only on the third) while requester 0 is valid throughout. Serial order is 2,2,2,0, and requester 0 is stalled when requester 2 pauses `req_valid` mid-packet.
- Packet lock undefined, same stimulus: words interleave 2,0,2,0,2.
